// File: rtl/seq_booth_multiplier.sv
// -----------------------------------------------------------------------------
// seq_booth_multiplier
//
// Iterative radix-4 Booth multiplier. It retires one Booth digit per clock.
// Operands are two's complement or unsigned, chosen per operation.
// Latency from the accepting start edge to the done pulse is WIDTH/2+2 cycles.
//
// Parameters:
//   WIDTH        operand width in bits (even, >= 4), default 32
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        request pulse, accepted only in IDLE
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   A, B         multiplicand / multiplier (sampled with start)
//   acc          (SEQ_MULT_ACCUMULATE_EN only) 1 = add the product into z
//   busy         high while digits are being retired (CALC)
//   done         one-cycle pulse, z holds a new result
//   z            2*WIDTH-bit result, held until the next result or reset
//
// Optional feature macro: SEQ_MULT_ACCUMULATE_EN adds the acc input and
// accumulate-into-z behaviour. The default build omits the acc port.
// -----------------------------------------------------------------------------
module seq_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
`ifdef SEQ_MULT_ACCUMULATE_EN
  input  logic                 acc,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  // Extended operand width. Two extra bits hold +-2M without overflow and let
  // an unsigned operand be seen as a positive signed value.
  localparam int EW = WIDTH + 2;
  // Product register: 2*EW bits plus the Booth guard bit at index 0.
  localparam int PW = 2 * EW + 1;
  // Number of Booth digits.
  localparam int N  = EW / 2;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [PW-1:0]        p_q,     p_d;
  logic [EW-1:0]        m_q,     m_d;
  logic [2*WIDTH-1:0]   z_q,     z_d;
`ifdef SEQ_MULT_ACCUMULATE_EN
  logic                 acc_q,   acc_d;
`endif

  // Operand extension for the operation about to be accepted.
  logic [EW-1:0] a_ext, b_ext;
  assign a_ext = signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
  assign b_ext = signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

  // One Booth step: decode {P[1:0], guard}, add the digit into the upper
  // half of P, then arithmetic-shift the whole register right by two.
  logic [EW-1:0]      m2;
  logic [EW-1:0]      addend;
  logic [EW-1:0]      sum;
  logic [PW-1:0]      p_added;
  logic [PW-1:0]      p_step;
  logic [2*WIDTH-1:0] product;

  assign m2 = {m_q[EW-2:0], 1'b0};

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here via the default arm); a missing branch would infer a latch.
  always_comb begin
    case (p_q[2:0])
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m2;
      3'b100:         addend = '0 - m2;
      3'b101, 3'b110: addend = '0 - m_q;
      default:        addend = '0;
    endcase
  end

  assign sum     = p_q[PW-1:EW+1] + addend;
  assign p_added = {sum, p_q[EW:0]};
  assign p_step  = {{2{p_added[PW-1]}}, p_added[PW-1:2]};
  // After N steps P has shifted by EW bits. The product sits above the guard.
  assign product = p_step[2*WIDTH:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    z_d     = z_q;
`ifdef SEQ_MULT_ACCUMULATE_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = a_ext;
          p_d     = {{EW{1'b0}}, b_ext, 1'b0};
          cnt_d   = '0;
`ifdef SEQ_MULT_ACCUMULATE_EN
          acc_d   = acc;
`endif
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        p_d   = p_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_DONE;
`ifdef SEQ_MULT_ACCUMULATE_EN
          z_d = acc_q ? (z_q + product) : product;
`else
          z_d = product;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the combinational next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      z_q     <= '0;
`ifdef SEQ_MULT_ACCUMULATE_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      z_q     <= z_d;
`ifdef SEQ_MULT_ACCUMULATE_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = (state_q == ST_CALC);
  assign done = (state_q == ST_DONE);
  assign z    = z_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_booth_multiplier
//
// Directed testbench for seq_booth_multiplier with WIDTH=32. Each scenario
// task drives its stimulus and checks hand-computed expectations inline.
// The accumulate scenario is compiled in only with SEQ_MULT_ACCUMULATE_EN.
// -----------------------------------------------------------------------------
module tb_seq_booth_multiplier;

  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 2 + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic              signed_mode;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              acc;
  logic              busy;
  logic              done;
  logic [2*WIDTH-1:0] z;

  int tests_run;
  int tests_failed;

  seq_booth_multiplier #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
`ifdef SEQ_MULT_ACCUMULATE_EN
    .acc         (acc),
`endif
    .busy        (busy),
    .done        (done),
    .z           (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge. Inputs change on the falling edge. On return we
  // sit at the falling edge one cycle after the accepting rising edge.
  task automatic pulse_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic sm, input logic ac);
    @(negedge clk);
    A = a; B = b; signed_mode = sm; acc = ac; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done. cycles counts negedges after the start edge, so
  // a nominal operation reports N+1. busy_cycles counts busy samples.
  task automatic wait_done(output int cycles, output int busy_cycles, output bit timed_out);
    cycles      = 1;
    busy_cycles = busy ? 1 : 0;
    timed_out   = 1'b0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b z=%h, expected 0 0 0", busy, done, z);
    end
  endtask

  // Multiply and check the result. Operands are scrambled after acceptance.
  task automatic run_check(input string name, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic sm, input logic ac,
                           input logic [2*WIDTH-1:0] exp_z);
    int cyc, bcyc;
    bit to;
    pulse_start(a, b, sm, ac);
    A = ~a; B = b ^ 32'h5A5A_A5A5; signed_mode = ~sm; acc = ~ac;
    wait_done(cyc, bcyc, to);
    tests_run++;
    if (to || z !== exp_z) begin
      tests_failed++;
      $display("FAIL %s: z=%h timed_out=%0d, expected z=%h", name, z, to, exp_z);
    end
  endtask

  task automatic test_signed_mix;
    int cyc, bcyc;
    bit to;
    pulse_start(32'hFFFF_FFF9, 32'd6, 1'b1, 1'b0);
    A = '0; B = '0; signed_mode = 1'b0;
    wait_done(cyc, bcyc, to);
    tests_run++;
    if (to || cyc != N + 1) begin
      tests_failed++;
      $display("FAIL signed_mix_latency: done after %0d cycles, expected %0d", cyc, N + 1);
    end
    tests_run++;
    if (bcyc != N) begin
      tests_failed++;
      $display("FAIL signed_mix_busy: busy for %0d cycles, expected %0d", bcyc, N);
    end
    tests_run++;
    if (z !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      tests_failed++;
      $display("FAIL signed_mix_z: z=%h, expected %h", z, 64'hFFFF_FFFF_FFFF_FFD6);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL signed_mix_done_width: done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_extremes;
    run_check("unsigned_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_check("signed_minus1_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h0000_0000_0000_0001);
    run_check("signed_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 64'h4000_0000_0000_0000);
    run_check("signed_min_x1", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000);
    run_check("unsigned_mixed", 32'h8000_0000, 32'h0000_0003, 1'b0, 1'b0, 64'h0000_0001_8000_0000);
    run_check("zero_operand", 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_start_while_busy;
    int pulses;
    int cyc, bcyc;
    bit to;
    logic [2*WIDTH-1:0] z_idle;
    pulse_start(32'd3, 32'd5, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    A = 32'd100; B = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    tests_run++;
    if (z !== 64'd15) begin
      tests_failed++;
      $display("FAIL busy_start_z: z=%h, expected %h", z, 64'd15);
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL busy_start_pulses: %0d done pulses, expected 1", pulses);
    end
    // z must stay put while idle with inputs moving.
    z_idle = z;
    A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    repeat (3) @(negedge clk);
    tests_run++;
    if (z !== 64'd15) begin
      tests_failed++;
      $display("FAIL idle_hold_z: z=%h, expected %h (was %h)", z, 64'd15, z_idle);
    end
    pulse_start(32'd100, 32'd100, 1'b0, 1'b0);
    wait_done(cyc, bcyc, to);
    tests_run++;
    if (to || z !== 64'd10000) begin
      tests_failed++;
      $display("FAIL after_busy_z: z=%h, expected %h", z, 64'd10000);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc, gap;
    bit to;
    @(negedge clk);
    A = 32'd7; B = 32'd8; signed_mode = 1'b0; acc = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done(cyc, bcyc, to);
    tests_run++;
    if (to || z !== 64'd56) begin
      tests_failed++;
      $display("FAIL held_start_first: z=%h, expected %h", z, 64'd56);
    end
    A = 32'd9;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done && gap < 100);
    start = 1'b0;
    tests_run++;
    if (gap != N + 2 || z !== 64'd72) begin
      tests_failed++;
      $display("FAIL held_start_second: gap=%0d z=%h, expected gap=%0d z=%h", gap, z, N + 2, 64'd72);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int pulses;
    int cyc, bcyc;
    bit to;
    pulse_start(32'd9, 32'd9, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== '0) begin
      tests_failed++;
      $display("FAIL mid_op_reset: busy=%b done=%b z=%h, expected 0 0 0", busy, done, z);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    tests_run++;
    if (pulses != 0 || z !== '0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: %0d busy/done cycles, z=%h, expected 0 and 0", pulses, z);
    end
    pulse_start(32'd2, 32'd3, 1'b0, 1'b0);
    wait_done(cyc, bcyc, to);
    tests_run++;
    if (to || z !== 64'd6) begin
      tests_failed++;
      $display("FAIL post_reset_mul: z=%h, expected %h", z, 64'd6);
    end
  endtask

`ifdef SEQ_MULT_ACCUMULATE_EN
  task automatic test_accumulate;
    run_check("acc_load", 32'd3, 32'd4, 1'b0, 1'b0, 64'd12);
    run_check("acc_add", 32'd5, 32'd6, 1'b0, 1'b1, 64'd42);
    run_check("acc_signed_cancel", 32'hFFFF_FFFF, 32'd42, 1'b1, 1'b1, 64'd0);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0; acc = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_signed_mix();
    test_extremes();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
`ifdef SEQ_MULT_ACCUMULATE_EN
    test_accumulate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Iterative radix-4 Booth multiplier, parametrised in operand width, with a selectable signed/unsigned mode. Retires one Booth digit per clock and uses a start/busy/done handshake. Next-generation replacement for the fully combinational 32x32 signed array multiplier in the ALU multiplier set. It trades latency for area and adds unsigned support.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  request pulse; accepted only in IDLE
signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start
A  input  WIDTH  multiplicand; sampled with start
B  input  WIDTH  multiplier; sampled with start
busy  output  1  high while a multiply is in progress (CALC)
done  output  1  one-cycle pulse: z holds a new result
z  output  2*WIDTH  product; held until the next result or reset

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0; done=0; z=0; all internal registers cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- Operand extension:
  - On acceptance, A and B extend to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - Iteration count N = WIDTH/2+1 (17 for WIDTH=32), identical for both modes.
- Datapath:
  - Product register P is 2*WIDTH+4 bits plus a Booth guard bit.
  - Each CALC cycle decodes the 3-bit window {P[1:0],guard} into a digit in {0, +-M, +-2M}, where M is the extended A.
  - The digit is added into the upper half of P, then P arithmetic-shifts right by 2.
  - All arithmetic wraps modulo the register width; there is no overflow flag.
- State machine: IDLE, CALC, DONE.
  - IDLE -> CALC when start=1:
    - latch operands; load P = {0, extended B, guard 0}; cnt = 0; busy goes high the next cycle.
  - CALC: one digit per cycle, cnt increments.
    - After the Nth digit (cnt = N-1), go to DONE.
    - At that edge, z <= low 2*WIDTH bits of the final product.
  - DONE: done=1, busy=0 for exactly one cycle, then unconditionally IDLE.
- Latency: start sampled at edge k -> busy high for cycles k+1..k+N -> done high in cycle k+N+1. Throughput is one result per N+2 cycles.
- start while busy or in DONE: ignored; operands are not re-sampled.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Inputs A, B and signed_mode may change freely after acceptance without affecting the result.
- z and done change only on the DONE-entry edge or on reset. z is stable across IDLE.

Optional Feature:
Macro SEQ_MULT_ACCUMULATE_EN.
- Defined:
  - Adds input port acc (1 bit), sampled with start.
  - When acc=1, the result written to z is (previous z + product) mod 2^(2*WIDTH).
  - When acc=0, z = product.
  - Reset clears the accumulator, since z=0.
  - Latency is unchanged; the addition happens in the DONE-entry cycle.
- Undefined: no acc port; z always equals the product.

Test Plan:
1. Signed sign mix (WIDTH=32): signed_mode=1, A=-7 (0xFFFFFFF9), B=6, start pulse -> done exactly 18 cycles after the start edge; z=0xFFFFFFFFFFFFFFD6; busy high for 17 cycles.
2. Unsigned maximum: signed_mode=0, A=B=0xFFFFFFFF -> z=0xFFFFFFFE00000001. The same operands with signed_mode=1 -> z=0x0000000000000001.
3. Signed minimum: A=B=0x80000000, signed_mode=1 -> z=0x4000000000000000. Then A=0x80000000, B=1 -> z=0xFFFFFFFF80000000.
4. Start while busy: A=3, B=5 start; 5 cycles later start with A=100, B=100 -> second start ignored; z=15, single done pulse; a subsequent start in IDLE with A=100, B=100 -> z=10000.
5. Reset mid-operation: start A=9, B=9; assert rst asynchronously at cycle 8 -> busy=0, done=0, z=0 immediately; no done after release; next start A=2, B=3 -> z=6.
6. SEQ_MULT_ACCUMULATE_EN build: A=3, B=4, acc=0 -> z=12; then A=5, B=6, acc=1 -> z=42; then A=-1, B=42, signed, acc=1 -> z=0.
